// File: rtl/ssd_scan.sv
// ----------------------------------------------------------------------------
// ssd_scan -- four-digit seven-segment display scanner.
//
// Samples the divided scan clock as plain data, turns each rising edge into a
// one-cycle tick, and on every tick selects the next digit, decodes its nibble
// from a frame-latched copy of value, and drives the active-low display lines.
//
// Ports:
//   clk       system clock, all state updates on its rising edge
//   rst_n     asynchronous active-low reset
//   clk_scan  divided scan clock, sampled as asynchronous data
//   value     four nibbles, [3:0] = digit 0 (rightmost), [15:12] = digit 3
//   dp_in     decimal-point request, bit i = digit i
//   ssd_ctl   digit enables, active-low, one-hot-low while scanning
//   segs      segments, active-low, {a,b,c,d,e,f,g,dp} from bit 7 down
//
// Parameter:
//   SYNC_STAGES  synchronizer depth on clk_scan (2..3)
//
// Build option:
//   SSD_LZB_EN   when defined, leading zeros on digits 3..1 are blanked
//
// State       | meaning
// ------------+----------------------------------------------------------
// run = 0     | idle after reset, display off, waiting for first tick
// run = 1     | scanning; idx is the digit currently driven
// ----------------------------------------------------------------------------
module ssd_scan #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_scan,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  ssd_ctl,
  output logic [7:0]  segs
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_q;

  logic [1:0]  idx;
  logic        run;
  logic [15:0] snap;
  logic [3:0]  dp_snap;

  logic        frame_start;
  logic [1:0]  nxt_idx;
  logic [15:0] src_val;
  logic [3:0]  src_dp;
  logic [3:0]  nib;
  logic        dp_bit;
  logic        blank;
  logic [3:0]  ctl_nxt;
  logic [7:0]  segs_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h01;
      4'h1: g = 7'h4F;
      4'h2: g = 7'h12;
      4'h3: g = 7'h06;
      4'h4: g = 7'h4C;
      4'h5: g = 7'h24;
      4'h6: g = 7'h20;
      4'h7: g = 7'h0F;
      4'h8: g = 7'h00;
      4'h9: g = 7'h04;
      4'hA: g = 7'h08;
      4'hB: g = 7'h60;
      4'hC: g = 7'h31;
      4'hD: g = 7'h42;
      4'hE: g = 7'h30;
      default: g = 7'h38;
    endcase
    return g;
  endfunction

  // Synchronizer, history flop and registered edge detect. Registering the
  // tick puts the display update SYNC_STAGES+1 edges after the sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1)
        sync_q <= {sync_q[SYNC_STAGES-2:0], clk_scan};
      else
        sync_q[0] <= clk_scan;
      hist_q <= sync_q[SYNC_STAGES-1];
      tick_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  // Next-digit decode. On a frame-start tick the incoming value/dp_in are
  // decoded directly so the first digit of a frame never shows stale data.
  always_comb begin
    frame_start = !run || (idx == 2'd3);
    nxt_idx     = run ? idx + 2'd1 : 2'd0;
    src_val     = frame_start ? value : snap;
    src_dp      = frame_start ? dp_in : dp_snap;
    nib         = src_val[{nxt_idx, 2'b00} +: 4];
    dp_bit      = src_dp[nxt_idx];
    ctl_nxt     = ~(4'b0001 << nxt_idx);
    blank       = 1'b0;
`ifdef SSD_LZB_EN
    // Blank when this nibble and every higher one are zero and no dp is lit.
    blank = (nxt_idx != 2'd0) && ((src_val >> {nxt_idx, 2'b00}) == 16'h0000)
            && !dp_bit;
`endif
    segs_nxt = blank ? 8'hFF : {glyph(nib), ~dp_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= 2'd0;
      run     <= 1'b0;
      snap    <= 16'h0000;
      dp_snap <= 4'h0;
      ssd_ctl <= 4'b1111;
      segs    <= 8'hFF;
    end else if (tick_q) begin
      run     <= 1'b1;
      idx     <= nxt_idx;
      ssd_ctl <= ctl_nxt;
      segs    <= segs_nxt;
      if (frame_start) begin
        snap    <= value;
        dp_snap <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan.sv
module tb_ssd_scan;

  logic        clk;
  logic        rst_n;
  logic        clk_scan;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  ssd_ctl;
  logic [7:0]  segs;

  int vecs = 0;
  int errs = 0;

  ssd_scan dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_scan (clk_scan),
    .value    (value),
    .dp_in    (dp_in),
    .ssd_ctl  (ssd_ctl),
    .segs     (segs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected segment bytes {glyph, ~dp}
  localparam logic [7:0] S_4 = 8'h99;
  localparam logic [7:0] S_3 = 8'h0D;
  localparam logic [7:0] S_2 = 8'h25;
  localparam logic [7:0] S_1 = 8'h9F;
  localparam logic [7:0] S_0 = 8'h03;
  localparam logic [7:0] S_D = 8'h85;
  localparam logic [7:0] S_C = 8'h63;
  localparam logic [7:0] S_B = 8'hC1;
  localparam logic [7:0] S_A = 8'h11;

  task automatic check(input string tag, input logic [3:0] ctl_exp,
                       input logic [7:0] segs_exp);
    vecs++;
    assert (ssd_ctl === ctl_exp && segs === segs_exp) else begin
      errs++;
      $error("FAIL %s: ssd_ctl=%b segs=%h, expected ssd_ctl=%b segs=%h",
             tag, ssd_ctl, segs, ctl_exp, segs_exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clean scan period: 4 cycles high, 4 low; display settles inside it.
  task automatic scan_tick();
    clk_scan = 1'b1;
    repeat (4) @(negedge clk);
    clk_scan = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Count ssd_ctl changes over n cycles.
  task automatic count_changes(input int n, output int c);
    logic [3:0] prev;
    prev = ssd_ctl;
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (ssd_ctl !== prev) c++;
      prev = ssd_ctl;
    end
  endtask

  initial begin
    int c;
    int bad;
    logic [3:0] ctl_seq [4];
    logic [7:0] s1234 [4];
    ctl_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    s1234   = '{S_4, S_3, S_2, S_1};

    rst_n = 1'b0; clk_scan = 1'b0; value = 16'h0000; dp_in = 4'h0;
    repeat (3) @(negedge clk);
    check("reset", 4'b1111, 8'hFF);

    // Idle with clk_scan low: display must stay off, nothing moves.
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ssd_ctl !== 4'b1111 || segs !== 8'hFF) bad++;
    end
    check_int("idle_off_cycles_bad", bad, 0);

    // Two full frames of 1234.
    value = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      scan_tick();
      check($sformatf("v1234_t%0d", i), ctl_seq[i % 4], s1234[i % 4]);
    end

    // Value changes mid-frame: frame keeps old digits, next frame shows ABCD.
    scan_tick(); check("mid_d0", ctl_seq[0], S_4);
    scan_tick(); check("mid_d1", ctl_seq[1], S_3);
    scan_tick(); check("mid_d2", ctl_seq[2], S_2);
    value = 16'hABCD;
    scan_tick(); check("mid_d3_old", ctl_seq[3], S_1);
    scan_tick(); check("abcd_d0", ctl_seq[0], S_D);
    scan_tick(); check("abcd_d1", ctl_seq[1], S_C);
    scan_tick(); check("abcd_d2", ctl_seq[2], S_B);
    scan_tick(); check("abcd_d3", ctl_seq[3], S_A);

    // Decimal point on digit 2 only.
    dp_in = 4'b0100;
    scan_tick(); check("dp_d0", ctl_seq[0], S_D);
    scan_tick(); check("dp_d1", ctl_seq[1], S_C);
    scan_tick(); check("dp_d2", ctl_seq[2], S_B & 8'hFE);
    scan_tick(); check("dp_d3", ctl_seq[3], S_A);
    dp_in = 4'b0000;

    // One-cycle glitch: never more than one tick.
    clk_scan = 1'b1;
    @(negedge clk);
    clk_scan = 1'b0;
    count_changes(20, c);
    vecs++;
    assert (c <= 1) else begin
      errs++;
      $error("FAIL glitch_ticks: observed %0d, expected at most 1", c);
    end

    // Held high: exactly one tick; then nothing while low.
    clk_scan = 1'b1;
    count_changes(50, c);
    check_int("held_high_ticks", c, 1);
    clk_scan = 1'b0;
    count_changes(10, c);
    check_int("low_after_held_ticks", c, 0);

    // Reach digit 2, then reset asynchronously.
    bad = 1;
    for (int i = 0; i < 5 && bad != 0; i++) begin
      if (ssd_ctl === 4'b1011) bad = 0;
      else scan_tick();
    end
    check_int("reach_digit2_timeout", bad, 0);
    #2 rst_n = 1'b0;
    #1 check("async_reset_now", 4'b1111, 8'hFF);
    @(negedge clk);
    check("reset_held", 4'b1111, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_release", 4'b1111, 8'hFF);
    scan_tick(); check("restart_d0", ctl_seq[0], S_D);

    // Leading zeros: 0042 then 0000.
    value = 16'h0042;
    scan_tick(); scan_tick(); scan_tick();
`ifdef SSD_LZB_EN
    scan_tick(); check("z42_d0", ctl_seq[0], S_2);
    scan_tick(); check("z42_d1", ctl_seq[1], S_4);
    scan_tick(); check("z42_d2", ctl_seq[2], 8'hFF);
    scan_tick(); check("z42_d3", ctl_seq[3], 8'hFF);
    value = 16'h0000;
    scan_tick(); check("z0_d0", ctl_seq[0], S_0);
    scan_tick(); check("z0_d1", ctl_seq[1], 8'hFF);
    scan_tick(); check("z0_d2", ctl_seq[2], 8'hFF);
    scan_tick(); check("z0_d3", ctl_seq[3], 8'hFF);
`else
    scan_tick(); check("z42_d0", ctl_seq[0], S_2);
    scan_tick(); check("z42_d1", ctl_seq[1], S_4);
    scan_tick(); check("z42_d2", ctl_seq[2], S_0);
    scan_tick(); check("z42_d3", ctl_seq[3], S_0);
    value = 16'h0000;
    scan_tick(); check("z0_d0", ctl_seq[0], S_0);
    scan_tick(); check("z0_d1", ctl_seq[1], S_0);
    scan_tick(); check("z0_d2", ctl_seq[2], S_0);
    scan_tick(); check("z0_d3", ctl_seq[3], S_0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
